// File: rtl/gl_operand_seq.sv
// Operand sequencer: fetches N operand words from BRAM after an opcode and hands them to decode.
// Optional abort input is enabled by defining GL_OPSEQ_ABORT_EN.
module gl_operand_seq #(
    parameter int width   = 32,
    parameter int MAX_OPS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       opcode,
    input  logic [width-1:0] base_addr,
    output logic [width-1:0] bram_addr,
    input  logic [width-1:0] bram_data,
    output logic [width-1:0] op_data,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [4:0]       op_index,
    output logic             op_last,
    output logic             busy,
    output logic             stall_fetch,
`ifdef GL_OPSEQ_ABORT_EN
    input  logic             abort,
`endif
    output logic             done
);

    localparam int CW = $clog2(MAX_OPS + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, HOLD, DONE} state_t;

    state_t         state, nxt;
    logic [CW-1:0]  n_dec, n_lat;
    logic [4:0]     last_idx;
    logic           abort_req;
    logic           hs;

    function automatic logic [CW-1:0] op_count(input logic [7:0] op);
        case (op)
            8'h03, 8'h04:                      return CW'(3);
            8'h11, 8'h13, 8'h16, 8'h17, 8'h18: return CW'(16);
            8'h19:                             return CW'(4);
            8'h1A:                             return CW'(6);
            default:                           return '0;
        endcase
    endfunction

    assign n_dec    = op_count(opcode);
    assign last_idx = 5'(n_lat) - 5'd1;
    assign hs       = op_valid & op_ready;

`ifdef GL_OPSEQ_ABORT_EN
    assign abort_req = abort & (state != IDLE);
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (start) nxt = (n_dec != '0) ? ISSUE : DONE;
            ISSUE:   nxt = CAPTURE;
            CAPTURE: nxt = HOLD;
            HOLD:    if (hs) nxt = op_last ? DONE : ISSUE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
        // Abort outranks a same-cycle handshake.
        if (abort_req) nxt = IDLE;
    end

    always_comb begin
        busy        = (state != IDLE);
        done        = (state == DONE);
        stall_fetch = busy | (start & (n_dec != '0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bram_addr <= '0;
            op_data   <= '0;
            op_index  <= '0;
            op_valid  <= 1'b0;
            op_last   <= 1'b0;
            n_lat     <= '0;
        end else if (abort_req) begin
            op_valid <= 1'b0;
            op_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start && n_dec != '0) begin
                    n_lat     <= n_dec;
                    bram_addr <= base_addr;
                    op_index  <= '0;
                end
                CAPTURE: begin
                    op_data  <= bram_data;
                    op_valid <= 1'b1;
                    op_last  <= (op_index == last_idx);
                end
                HOLD: if (hs) begin
                    op_valid <= 1'b0;
                    op_last  <= 1'b0;
                    if (!op_last) begin
                        bram_addr <= bram_addr + 1'b1;
                        op_index  <= op_index + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gl_operand_seq.sv
// Scoreboard bench for gl_operand_seq: a stimulus process queues the expected operand stream,
// a negedge monitor compares every handshake. Define GL_OPSEQ_ABORT_EN to exercise abort.
module tb_gl_operand_seq;

    logic        clk = 1'b0;
    logic        reset, start, op_ready;
    logic [7:0]  opcode;
    logic [31:0] base_addr, bram_addr, bram_data, op_data;
    logic        op_valid, op_last, busy, stall_fetch, done;
    logic [4:0]  op_index;
`ifdef GL_OPSEQ_ABORT_EN
    logic        abort;
`endif

    gl_operand_seq #(.width(32), .MAX_OPS(16)) dut (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode), .base_addr(base_addr),
        .bram_addr(bram_addr), .bram_data(bram_data), .op_data(op_data), .op_valid(op_valid),
        .op_ready(op_ready), .op_index(op_index), .op_last(op_last), .busy(busy),
        .stall_fetch(stall_fetch),
`ifdef GL_OPSEQ_ABORT_EN
        .abort(abort),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  idx;
        logic        last;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0, n_err = 0;
    int   done_cnt = 0, stall_seen = 0;
    int   bp_word = -1, bp_left = 0;
    bit   rand_ready = 0;

    // BRAM contents are a fixed scramble of the address, so every address yields a distinct word.
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    function automatic int nops(input logic [7:0] op);
        case (op)
            8'h03, 8'h04:                      return 3;
            8'h11, 8'h13, 8'h16, 8'h17, 8'h18: return 16;
            8'h19:                             return 4;
            8'h1A:                             return 6;
            default:                           return 0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) bram_data <= mem_f(bram_addr);

    // Ready driver: forced low for bp_left cycles on word bp_word, otherwise always-1 or random.
    initial begin
        op_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (bp_left > 0 && op_valid && int'(op_index) == bp_word) begin
                op_ready = 1'b0;
                bp_left--;
            end else if (rand_ready) op_ready = 1'($urandom_range(0, 1));
            else op_ready = 1'b1;
        end
    end

    // Monitor
    initial begin
        logic        prev_hold, prev_valid, ab, armed;
        logic [31:0] pdata;
        logic [4:0]  pidx;
        int          lat;
        exp_t        e;
        prev_hold = 0; prev_valid = 0; armed = 0; lat = 0; pdata = '0; pidx = '0;
        forever begin
            @(negedge clk);
`ifdef GL_OPSEQ_ABORT_EN
            ab = abort;
`else
            ab = 1'b0;
`endif
            if (reset || ab) begin
                armed = 0; prev_hold = 0; prev_valid = 0;
            end else begin
                lat++;
                if (!op_valid) chk("last_while_invalid", 64'(op_last), 64'd0);
                if (op_valid && !prev_valid && armed) chk("word_latency", 64'(lat), 64'd3);
                if (prev_hold && op_valid) begin
                    chk("hold_data_stable", 64'(op_data), 64'(pdata));
                    chk("hold_index_stable", 64'(op_index), 64'(pidx));
                end
                if (op_valid && !op_ready && int'(op_index) == bp_word) stall_seen++;
                if (op_valid && op_ready) begin
                    if (sb.size() == 0) chk("unexpected_word", 64'(op_data), 64'hDEAD);
                    else begin
                        e = sb.pop_front();
                        chk("op_data", 64'(op_data), 64'(e.data));
                        chk("op_index", 64'(op_index), 64'(e.idx));
                        chk("op_last", 64'(op_last), 64'(e.last));
                    end
                    lat = 0; armed = 1;
                end
                if (start && !busy && nops(opcode) > 0) begin lat = 0; armed = 1; end
                if (done) done_cnt++;
                prev_hold  = op_valid & ~op_ready;
                prev_valid = op_valid;
                pdata      = op_data;
                pidx       = op_index;
            end
        end
    end

    // One full sequence; ign_at>0 injects an ignored start that many cycles in, exp_done>=0 checks done timing.
    task automatic run_seq(input logic [7:0] op, input logic [31:0] base, input int ign_at,
                           input int exp_done);
        int   n, k, d0;
        logic sf0, sf_all, saw_valid, got;
        n = nops(op);
        for (int i = 0; i < n; i++) sb.push_back('{mem_f(base + 32'(i)), 5'(i), (i == n - 1)});
        d0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b1; opcode = op; base_addr = base;
        @(negedge clk);
        sf0 = stall_fetch;
        k = 0; sf_all = 1; saw_valid = 0; got = 0;
        while (k < 400 && !got) begin
            @(posedge clk); #1;
            start = (ign_at > 0 && k == ign_at);
            if (start) begin opcode = 8'h03; base_addr = 32'h100; end
            @(negedge clk);
            k++;
            sf_all    &= stall_fetch;
            saw_valid |= op_valid;
            got        = done;
        end
        chk("done_seen", 64'(got), 64'd1);
        if (exp_done >= 0) chk("done_latency", 64'(k), 64'(exp_done));
        if (n > 0) begin
            chk("stall_on_start", 64'(sf0), 64'd1);
            chk("stall_through_done", 64'(sf_all), 64'd1);
        end else begin
            chk("zero_no_stall_on_start", 64'(sf0), 64'd0);
            chk("zero_no_valid", 64'(saw_valid), 64'd0);
        end
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
        chk("done_pulse_once", 64'(done_cnt - d0), 64'd1);
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    task automatic wait_word(input int idx, output bit ok);
        ok = 0;
        for (int c = 0; c < 300 && !ok; c++) begin
            @(negedge clk);
            ok = op_valid && int'(op_index) == idx;
        end
        chk("reached_word", 64'(ok), 64'd1);
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_outputs"}, {bram_addr, op_data},  64'd0);
        chk({tag, "_flags"}, 64'({op_index, op_valid, op_last, done, busy}), 64'd0);
    endtask

    initial begin
        logic [7:0] ops[10] = '{8'h03, 8'h04, 8'h11, 8'h13, 8'h16, 8'h17, 8'h18, 8'h19, 8'h1A, 8'h55};
        bit ok;
        int d0;
        reset = 1; start = 0; opcode = '0; base_addr = '0;
`ifdef GL_OPSEQ_ABORT_EN
        abort = 0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_zero("reset_state");
        @(posedge clk); #1 reset = 0;

        // Vertex: three words, handshakes every 3 cycles, done one cycle after the last.
        run_seq(8'h03, 32'h10, 0, 10);

        // Backpressure on word 1 for 5 cycles.
        stall_seen = 0; bp_word = 1; bp_left = 5;
        run_seq(8'h19, 32'h200, 0, 18);
        chk("bp_stall_cycles", 64'(stall_seen), 64'd5);
        bp_word = -1; bp_left = 0;

        // Zero-operand opcode: done in the very next cycle.
        run_seq(8'h01, 32'h40, 0, 1);

        // Address wrap plus an ignored start mid-sequence.
        run_seq(8'h13, 32'hFFFF_FFFE, 7, 49);

        // Reset while word 7 of a 16-word sequence is held.
        for (int i = 0; i < 16; i++) sb.push_back('{mem_f(32'h300 + 32'(i)), 5'(i), (i == 15)});
        bp_word = 7; bp_left = 4;
        @(posedge clk); #1 start = 1; opcode = 8'h11; base_addr = 32'h300;
        @(posedge clk); #1 start = 0;
        wait_word(7, ok);
        @(posedge clk); #1 reset = 1;
        @(negedge clk);
        @(posedge clk); #1 reset = 0;
        sb.delete(); bp_left = 0; bp_word = -1;
        @(negedge clk);
        check_idle_zero("mid_reset");
        run_seq(8'h03, 32'h500, 0, 10);

`ifdef GL_OPSEQ_ABORT_EN
        // Abort while word 2 is held: back to IDLE, no done pulse.
        for (int i = 0; i < 6; i++) sb.push_back('{mem_f(32'h600 + 32'(i)), 5'(i), (i == 5)});
        bp_word = 2; bp_left = 4;
        @(posedge clk); #1 start = 1; opcode = 8'h1A; base_addr = 32'h600;
        @(posedge clk); #1 start = 0;
        wait_word(2, ok);
        d0 = done_cnt;
        @(posedge clk); #1 abort = 1;
        @(posedge clk); #1 abort = 0;
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_valid_last", 64'({op_valid, op_last}), 64'd0);
        repeat (3) @(negedge clk);
        chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
        sb.delete(); bp_left = 0; bp_word = -1;
`else
        d0 = 0;
`endif

        // Random opcodes, bases and ready patterns.
        rand_ready = 1;
        for (int r = 0; r < 8; r++)
            run_seq(ops[$urandom_range(0, 9)], $urandom, 0, -1);
        rand_ready = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
